// File: rtl/output_frame_parser_if.sv
// Stream, body and result-record signals of output_frame_parser.
// Modport master is the parser side and slave is the surrounding logic.
interface output_frame_parser_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] body_data;
  logic        body_valid;
  logic        body_ready;
  logic [15:0] res_cycles;
  logic [7:0]  res_iterations;
  logic [15:0] res_word_count;
  logic [1:0]  res_flags;
  logic [31:0] res_checksum;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] frame_count;

  modport master (
    input  in_data, in_valid, body_ready, res_ready,
    output in_ready, body_data, body_valid,
           res_cycles, res_iterations, res_word_count, res_flags,
           res_checksum, res_valid, frame_count
  );

  modport slave (
    output in_data, in_valid, body_ready, res_ready,
    input  in_ready, body_data, body_valid,
           res_cycles, res_iterations, res_word_count, res_flags,
           res_checksum, res_valid, frame_count
  );
endinterface

// File: rtl/output_frame_parser.sv
// Splits decoder output frames (header, body words, 32'hFFFFFFFF terminator) into a
// zero-latency body stream and one result record per frame. OUTPUT_PARSER_CHECKSUM_EN adds the body XOR checksum.
//
// state  | meaning
// S_IDLE | waiting for a header or a lone terminator
// S_BODY | forwarding body words, watching for terminator / overflow / idle timeout
// S_DONE | result record presented, waiting for res_ready
module output_frame_parser #(
  parameter int MAX_WORDS      = 4096,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  output_frame_parser_if.master  pif
);

  localparam logic [31:0] TERM = 32'hFFFF_FFFF;
  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_BODY, S_DONE} state_t;

  state_t          state;
  logic [TW-1:0]   idle_left;
  logic [15:0]     word_cnt;
  logic [15:0]     cyc_q;
  logic [7:0]      iter_q;
  logic [1:0]      flags_q;
  logic            res_valid_q;
  logic [31:0]     frame_cnt_q;

  logic            is_term;
  logic            room;
  logic            in_rdy;
  logic            accept;

  assign is_term = (pif.in_data == TERM);
  assign room    = ({16'd0, word_cnt} < 32'(MAX_WORDS));

  always_comb begin
    in_rdy = 1'b0;
    case (state)
      S_IDLE:  in_rdy = 1'b1;
      S_BODY:  in_rdy = (is_term || !room) ? 1'b1 : pif.body_ready;
      default: in_rdy = 1'b0;
    endcase
  end

  assign accept         = pif.in_valid && in_rdy;
  assign pif.in_ready   = in_rdy;
  assign pif.body_valid = (state == S_BODY) && pif.in_valid && !is_term && room;
  assign pif.body_data  = pif.in_data;

  assign pif.res_cycles     = cyc_q;
  assign pif.res_iterations = iter_q;
  assign pif.res_word_count = word_cnt;
  assign pif.res_flags      = flags_q;
  assign pif.res_valid      = res_valid_q;
  assign pif.frame_count    = frame_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      idle_left   <= '0;
      word_cnt    <= '0;
      cyc_q       <= '0;
      iter_q      <= '0;
      flags_q     <= '0;
      res_valid_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            word_cnt <= '0;
            flags_q  <= '0;
            if (is_term) begin
              cyc_q       <= '0;
              iter_q      <= '0;
              res_valid_q <= 1'b1;
              state       <= S_DONE;
            end else begin
              cyc_q     <= pif.in_data[15:0];
              iter_q    <= pif.in_data[23:16];
              idle_left <= TW'(TIMEOUT_CYCLES);
              state     <= S_BODY;
            end
          end
        end
        S_BODY: begin
          // Any valid cycle counts as activity, even if stalled by body_ready.
          if (pif.in_valid) begin
            idle_left <= TW'(TIMEOUT_CYCLES);
            if (accept) begin
              if (is_term) begin
                res_valid_q <= 1'b1;
                state       <= S_DONE;
              end else begin
                if (word_cnt != 16'hFFFF) word_cnt <= word_cnt + 16'd1;
                if (!room) flags_q[0] <= 1'b1;
              end
            end
          end else if (idle_left <= TW'(1)) begin
            flags_q[1]  <= 1'b1;
            res_valid_q <= 1'b1;
            state       <= S_DONE;
          end else begin
            idle_left <= idle_left - TW'(1);
          end
        end
        S_DONE: begin
          if (res_valid_q && pif.res_ready) begin
            res_valid_q <= 1'b0;
            frame_cnt_q <= frame_cnt_q + 32'd1;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef OUTPUT_PARSER_CHECKSUM_EN
  logic [31:0] cks_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cks_q <= '0;
    end else if (state == S_IDLE && accept) begin
      cks_q <= '0;
    end else if (state == S_BODY && accept && !is_term) begin
      cks_q <= cks_q ^ pif.in_data;
    end
  end

  assign pif.res_checksum = cks_q;
`else
  assign pif.res_checksum = '0;
`endif

endmodule

// File: tb/tb_output_frame_parser.sv
// Randomized frame stimulus for output_frame_parser, checked against a frame-level model
// (expected forwarded words and result records computed from whole frames).
module tb_output_frame_parser;

  localparam int MAX_W = 4;
  localparam int TMO   = 8;
  localparam logic [31:0] TERM = 32'hFFFF_FFFF;

  typedef struct {
    logic [15:0] cyc;
    logic [7:0]  it;
    logic [15:0] cnt;
    logic [1:0]  flags;
    logic [31:0] cks;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  output_frame_parser_if dif();

  output_frame_parser #(.MAX_WORDS(MAX_W), .TIMEOUT_CYCLES(TMO)) dut (
    .clk   (clk),
    .reset (reset),
    .pif   (dif)
  );

  int checks = 0;
  int errors = 0;
  int n_results = 0;
  int ready_mode = 0;
  logic man_br = 1'b1;
  logic man_rr = 1'b1;

  logic [31:0] exp_body[$];
  res_t        exp_res[$];
  logic [31:0] body_w[16];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic finish_sim();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Sink readiness: 0 always ready, 1 random, 2 manual via man_br/man_rr.
  initial begin
    dif.body_ready = 1'b1;
    dif.res_ready  = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0: begin dif.body_ready = 1'b1; dif.res_ready = 1'b1; end
        1: begin
          dif.body_ready = ($urandom_range(0, 3) != 0);
          dif.res_ready  = ($urandom_range(0, 1) != 0);
        end
        default: begin dif.body_ready = man_br; dif.res_ready = man_rr; end
      endcase
    end
  end

  // Output monitor: body transfers, result records, result stability while stalled.
  initial begin
    res_t r;
    bit held = 0;
    res_t hold_r;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (dif.body_valid) begin
          check_eq("in_rdy_fwd", 32'(dif.in_ready), 32'(dif.body_ready));
          if (dif.body_ready) begin
            if (exp_body.size() == 0) check_eq("body_extra", 32'(1), 32'(0));
            else check_eq("body_data", dif.body_data, exp_body.pop_front());
          end
        end
        if (held) begin
          check_eq("hold_cycles", 32'(dif.res_cycles), 32'(hold_r.cyc));
          check_eq("hold_count", 32'(dif.res_word_count), 32'(hold_r.cnt));
          check_eq("hold_flags", 32'(dif.res_flags), 32'(hold_r.flags));
          check_eq("hold_valid", 32'(dif.res_valid), 32'(1));
        end
        if (dif.res_valid && dif.res_ready) begin
          if (exp_res.size() == 0) begin
            check_eq("res_extra", 32'(1), 32'(0));
          end else begin
            r = exp_res.pop_front();
            check_eq("res_cycles", 32'(dif.res_cycles), 32'(r.cyc));
            check_eq("res_iterations", 32'(dif.res_iterations), 32'(r.it));
            check_eq("res_word_count", 32'(dif.res_word_count), 32'(r.cnt));
            check_eq("res_flags", 32'(dif.res_flags), 32'(r.flags));
            check_eq("res_checksum", dif.res_checksum, r.cks);
            check_eq("frame_count", dif.frame_count, 32'(n_results));
          end
          n_results++;
        end
        held = dif.res_valid && !dif.res_ready;
        hold_r.cyc   = dif.res_cycles;
        hold_r.cnt   = dif.res_word_count;
        hold_r.flags = dif.res_flags;
      end else begin
        held = 0;
      end
    end
  end

  initial begin
    #300000;
    check_eq("watchdog", 32'(0), 32'(1));
    finish_sim();
  end

  task automatic send_word(input logic [31:0] w);
    int budget = 0;
    bit acc = 0;
    dif.in_data  = w;
    dif.in_valid = 1'b1;
    while (!acc) begin
      @(negedge clk);
      acc = dif.in_ready;
      @(posedge clk);
      #1;
      budget++;
      if (!acc && budget > 300) begin
        check_eq("in_accept_timeout", 32'(0), 32'(1));
        finish_sim();
      end
    end
    dif.in_valid = 1'b0;
    dif.in_data  = $urandom;
  endtask

  task automatic idle(input int n);
    dif.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [31:0] hdr, input int n, input bit tmo,
                            input bit lone, input bit gaps);
    res_t r;
    logic [31:0] x = 32'd0;
    r.cyc = '0; r.it = '0; r.cnt = '0; r.flags = '0; r.cks = '0;
    if (lone) begin
      exp_res.push_back(r);
      send_word(TERM);
      return;
    end
    for (int i = 0; i < n; i++) begin
      x ^= body_w[i];
      if (i < MAX_W) exp_body.push_back(body_w[i]);
    end
    r.cyc   = hdr[15:0];
    r.it    = hdr[23:16];
    r.cnt   = 16'(n);
    r.flags = {tmo, (n > MAX_W)};
`ifdef OUTPUT_PARSER_CHECKSUM_EN
    r.cks = x;
`else
    r.cks = 32'd0;
`endif
    exp_res.push_back(r);
    send_word(hdr);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      send_word(body_w[i]);
    end
    if (tmo) idle(TMO + 4);
    else begin
      if (gaps) idle($urandom_range(0, 2));
      send_word(TERM);
    end
  endtask

  task automatic fill_body(input int n);
    for (int i = 0; i < n; i++) begin
      body_w[i] = $urandom;
      if (body_w[i] == TERM) body_w[i] = 32'd0;
    end
  endtask

  task automatic wait_drain();
    int budget = 0;
    while ((exp_res.size() != 0 || exp_body.size() != 0) && budget < 400) begin
      @(posedge clk);
      budget++;
    end
    #1;
    check_eq("drain_res_left", 32'(exp_res.size()), 32'(0));
    check_eq("drain_body_left", 32'(exp_body.size()), 32'(0));
  endtask

  function automatic logic [31:0] rand_hdr();
    logic [31:0] h = $urandom;
    if (h == TERM) h = 32'h0;
    return h;
  endfunction

  initial begin
    dif.in_valid = 1'b0;
    dif.in_data  = '0;
    #3;
    check_eq("rst_in_ready", 32'(dif.in_ready), 32'(1));
    check_eq("rst_body_valid", 32'(dif.body_valid), 32'(0));
    check_eq("rst_res_valid", 32'(dif.res_valid), 32'(0));
    check_eq("rst_frame_count", dif.frame_count, 32'(0));
    check_eq("rst_word_count", 32'(dif.res_word_count), 32'(0));
    check_eq("rst_checksum", dif.res_checksum, 32'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(2);

    // Basic frame, sinks always ready.
    ready_mode = 0;
    body_w[0] = 32'h11;
    body_w[1] = 32'h22;
    send_frame(32'h0003_0120, 2, 0, 0, 0);
    wait_drain();
    check_eq("basic_frame_count", dif.frame_count, 32'(1));

    // Lone terminator.
    send_frame(32'h0, 0, 0, 1, 0);
    wait_drain();

    // Overflow, and terminator exactly at MAX_WORDS.
    fill_body(6);
    send_frame(rand_hdr(), 6, 0, 0, 0);
    fill_body(MAX_W);
    send_frame(rand_hdr(), MAX_W, 0, 0, 0);
    wait_drain();

    // Idle timeout, then the next word must be taken as a header.
    fill_body(1);
    send_frame(rand_hdr(), 1, 1, 0, 0);
    fill_body(2);
    send_frame(32'h0005_0042, 2, 0, 0, 0);
    wait_drain();

    // Directed body stall and result hold.
    ready_mode = 2;
    man_br = 1'b1;
    man_rr = 1'b0;
    fill_body(3);
    send_frame_stall();
    wait_drain();

    // Randomized frames with random sink readiness.
    ready_mode = 1;
    for (int f = 0; f < 40; f++) begin
      int n = $urandom_range(0, 7);
      bit tmo = ($urandom_range(0, 9) == 0);
      bit lone = ($urandom_range(0, 9) == 0);
      fill_body(n);
      send_frame(rand_hdr(), n, tmo, lone, 1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 4));
    end
    wait_drain();

    // Reset in the middle of a frame.
    ready_mode = 0;
    idle(2);
    fill_body(2);
    exp_body.push_back(body_w[0]);
    exp_body.push_back(body_w[1]);
    send_word(rand_hdr());
    send_word(body_w[0]);
    send_word(body_w[1]);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", 32'(dif.in_ready), 32'(1));
    check_eq("mid_rst_body_valid", 32'(dif.body_valid), 32'(0));
    check_eq("mid_rst_res_valid", 32'(dif.res_valid), 32'(0));
    check_eq("mid_rst_frame_count", dif.frame_count, 32'(0));
    check_eq("mid_rst_word_count", 32'(dif.res_word_count), 32'(0));
    check_eq("mid_rst_cycles", 32'(dif.res_cycles), 32'(0));
    check_eq("mid_rst_flags", 32'(dif.res_flags), 32'(0));
    n_results = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    idle(5);
    check_eq("mid_rst_no_result", 32'(dif.res_valid), 32'(0));
    fill_body(3);
    send_frame(rand_hdr(), 3, 0, 0, 0);
    wait_drain();
    check_eq("post_rst_frame_count", dif.frame_count, 32'(1));
    finish_sim();
  end

  // Body stalled for 5 cycles on the second word, result held 3 cycles.
  task automatic send_frame_stall();
    res_t r;
    logic [31:0] hdr = 32'h0002_0777;
    exp_body.push_back(body_w[0]);
    exp_body.push_back(body_w[1]);
    exp_body.push_back(body_w[2]);
    r.cyc = hdr[15:0];
    r.it  = hdr[23:16];
    r.cnt = 16'd3;
    r.flags = 2'b00;
`ifdef OUTPUT_PARSER_CHECKSUM_EN
    r.cks = body_w[0] ^ body_w[1] ^ body_w[2];
`else
    r.cks = 32'd0;
`endif
    exp_res.push_back(r);
    send_word(hdr);
    send_word(body_w[0]);
    man_br = 1'b0;
    fork
      send_word(body_w[1]);
      begin
        repeat (5) begin
          @(negedge clk);
          check_eq("stall_in_ready", 32'(dif.in_ready), 32'(0));
          check_eq("stall_body_valid", 32'(dif.body_valid), 32'(1));
        end
        man_br = 1'b1;
      end
    join
    send_word(body_w[2]);
    send_word(TERM);
    @(negedge clk);
    check_eq("res_latency", 32'(dif.res_valid), 32'(1));
    repeat (3) begin
      @(negedge clk);
      check_eq("done_res_valid", 32'(dif.res_valid), 32'(1));
      check_eq("done_in_ready", 32'(dif.in_ready), 32'(0));
    end
    @(posedge clk);
    #1 man_rr = 1'b1;
  endtask

endmodule
